data_path: RTL and testbench
============================

# data_path

Minimal 8-bit register-transfer datapath: three registers (RA, RB, RZ) share one internal bus, with an immediate adder feeding RZ. Each register is controlled by separate one-hot-style out/in strobes, which an external control sequencer (state machine or testbench) drives. It is the Phase 1 bring-up vehicle for the CPU bus/register-transfer scheme, before the full register file and ALU are added.

## Interface
Parameters: none (width fixed at 8 bits).

Ports, in positional order (the first ten are fixed; observation outputs are appended):
- clock  in  1  system clock; all state updates on rising edge
- clear  in  1  asynchronous, active-low reset; clears every register
- AddImmediate  in  8  constant added to the bus value when loading RZ
- RegisterAImmediate  in  8  immediate load value for RA when no register drives the bus
- RZout  in  1  RZ drives bus
- RAout  in  1  RA drives bus
- RBout  in  1  RB drives bus
- RAin  in  1  load enable for RA
- RBin  in  1  load enable for RB
- RZin  in  1  load enable for RZ
- BusMuxOut  out  8  current internal bus value (combinational)
- RAdata  out  8  RA contents
- RBdata  out  8  RB contents
- RZdata  out  8  RZ contents

## Operation
- Bus source selection uses fixed priority when more than one out strobe is high:
  - RZout > RAout > RBout.
  - If no out strobe is high, the bus equals RegisterAImmediate.
- Adder: sum = BusMuxOut + AddImmediate, unsigned 8-bit; the carry-out is discarded and the result wraps (0xFF + 0x01 = 0x00).
- Register loads on the rising clock edge:
  - RAin=1: RA <= BusMuxOut. With no out strobe high, this is an immediate load from RegisterAImmediate.
  - RBin=1: RB <= BusMuxOut.
  - RZin=1: RZ <= adder sum.
- Registers whose in-strobe is low hold their value.
- Multiple in strobes may be high in the same cycle. All enabled registers load, and every one of them uses the pre-edge bus value.
- Self-transfer is legal: RAout=1 with RAin=1 reloads the same RA value. RZout=1 with RZin=1 gives RZ <= RZ + AddImmediate (accumulate).
- No internal state machine; sequencing is entirely external.

## Timing
- Reset: clear=0 asynchronously forces RA=RB=RZ=0x00 (and ZCarry=0 when configured). This takes effect immediately, regardless of clock.
- While clear=0, load strobes are ignored. Release is synchronous-safe: the first load happens on the first rising edge with clear=1.
- BusMuxOut and the adder sum are purely combinational from the strobes, the immediates and the current register values. There are no registered outputs other than the registers themselves.
- Load latency: one edge. A value placed on the bus with its in-strobe high before rising edge N appears on the register output after edge N.
- The sequencer changes strobes on the falling edge; setup is half a clock period.
- Reset asserted mid-transfer: the pending load is lost and the registers read 0 after reset.

## Configuration
- DATAPATH_CARRY_EN defined:
  - Adds output port ZCarry (1 bit), placed after RZdata.
  - ZCarry is a register loaded with the adder carry-out whenever RZin=1, holds otherwise, and is cleared by reset.
- Not defined: no ZCarry port; the carry-out is discarded.
- The 8-bit arithmetic result is identical in both builds.

## Test plan
- Reset: assert clear=0 mid-cycle with registers non-zero -> RA, RB, RZ read 0x00 immediately, without waiting for a clock edge.
- Immediate load: RegisterAImmediate=0x05, RAin=1, no out strobes, one edge -> RAdata=0x05, BusMuxOut=0x05 during the cycle.
- Add-immediate: RA=0x05, RAout=1, AddImmediate=0x05, RZin=1, one edge -> RZdata=0x0A, RA unchanged.
- Move: RZout=1, RBin=1, one edge -> RBdata=0x0A. Full three-cycle sequence (load, add, move) ends with RA=0x05, RB=0x0A, RZ=0x0A.
- Wrap/priority: RA=0xFF, RB=0x11, RAout=RBout=1, AddImmediate=0x01, RZin=1 -> bus=0xFF, RZ=0x00. ZCarry=1 when DATAPATH_CARRY_EN is defined.
- Hold/accumulate: all strobes low for 3 edges -> no register changes. Then RZout=RZin=1, AddImmediate=0x03 for two edges starting at RZ=0x0A -> RZ=0x10.

Source files
------------

// File: rtl/data_path.sv
// data_path: 8-bit three-register shared-bus datapath with an immediate adder into RZ.
// Define DATAPATH_CARRY_EN to add the registered ZCarry output.
module data_path (
    input  logic       clock,
    input  logic       clear,
    input  logic [7:0] AddImmediate,
    input  logic [7:0] RegisterAImmediate,
    input  logic       RZout,
    input  logic       RAout,
    input  logic       RBout,
    input  logic       RAin,
    input  logic       RBin,
    input  logic       RZin,
    output logic [7:0] BusMuxOut,
    output logic [7:0] RAdata,
    output logic [7:0] RBdata,
    output logic [7:0] RZdata
`ifdef DATAPATH_CARRY_EN
    ,
    output logic       ZCarry
`endif
);
    logic [7:0] r_ra, r_rb, r_rz;
    logic [7:0] w_bus, w_sum;

    always_comb w_bus = RZout ? r_rz : RAout ? r_ra : RBout ? r_rb : RegisterAImmediate;

`ifdef DATAPATH_CARRY_EN
    logic w_carry;
    logic r_zcarry;
    assign {w_carry, w_sum} = {1'b0, w_bus} + {1'b0, AddImmediate};
    always_ff @(posedge clock or negedge clear)
        if (!clear) r_zcarry <= 1'b0;
        else if (RZin) r_zcarry <= w_carry;
    assign ZCarry = r_zcarry;
`else
    assign w_sum = w_bus + AddImmediate;
`endif

    // all loads sample the pre-edge bus, so simultaneous/self transfers are safe
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_ra <= 8'h00;
            r_rb <= 8'h00;
            r_rz <= 8'h00;
        end else begin
            if (RAin) r_ra <= w_bus;
            if (RBin) r_rb <= w_bus;
            if (RZin) r_rz <= w_sum;
        end
    end

    assign BusMuxOut = w_bus;
    assign RAdata    = r_ra;
    assign RBdata    = r_rb;
    assign RZdata    = r_rz;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed self-checking bench for data_path (default and DATAPATH_CARRY_EN builds).
module tb_data_path;
    logic       clock = 1'b0;
    logic       clear;
    logic [7:0] AddImmediate, RegisterAImmediate;
    logic       RZout, RAout, RBout, RAin, RBin, RZin;
    logic [7:0] BusMuxOut, RAdata, RBdata, RZdata;
`ifdef DATAPATH_CARRY_EN
    logic       ZCarry;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear),
        .AddImmediate(AddImmediate), .RegisterAImmediate(RegisterAImmediate),
        .RZout(RZout), .RAout(RAout), .RBout(RBout),
        .RAin(RAin), .RBin(RBin), .RZin(RZin),
        .BusMuxOut(BusMuxOut), .RAdata(RAdata), .RBdata(RBdata), .RZdata(RZdata)
`ifdef DATAPATH_CARRY_EN
        , .ZCarry(ZCarry)
`endif
    );

    task automatic idle();
        {RZout, RAout, RBout, RAin, RBin, RZin} = 6'b0;
        AddImmediate = 8'h00;
        RegisterAImmediate = 8'h00;
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        idle();
        RAin = 1'b1; RBin = 1'b1; RZin = 1'b1; RegisterAImmediate = 8'h33;
        edge_sample();
        checks++; if (RAdata !== 8'h00) begin errors++; $display("FAIL reset_ra: got %h expected 00", RAdata); end
        checks++; if (RBdata !== 8'h00) begin errors++; $display("FAIL reset_rb: got %h expected 00", RBdata); end
        checks++; if (RZdata !== 8'h00) begin errors++; $display("FAIL reset_rz: got %h expected 00", RZdata); end
        @(negedge clock);
        idle();
        clear = 1'b1;
    endtask

    task automatic test_immediate_load();
        @(negedge clock);
        RegisterAImmediate = 8'h05; RAin = 1'b1;
        #1;
        checks++; if (BusMuxOut !== 8'h05) begin errors++; $display("FAIL imm_bus: got %h expected 05", BusMuxOut); end
        edge_sample();
        checks++; if (RAdata !== 8'h05) begin errors++; $display("FAIL imm_ra: got %h expected 05", RAdata); end
        @(negedge clock);
        idle();
    endtask

    task automatic test_add();
        @(negedge clock);
        RAout = 1'b1; AddImmediate = 8'h05; RZin = 1'b1;
        edge_sample();
        checks++; if (RZdata !== 8'h0A) begin errors++; $display("FAIL add_rz: got %h expected 0a", RZdata); end
        checks++; if (RAdata !== 8'h05) begin errors++; $display("FAIL add_ra_hold: got %h expected 05", RAdata); end
        @(negedge clock);
        idle();
    endtask

    task automatic test_move();
        @(negedge clock);
        RZout = 1'b1; RBin = 1'b1; RegisterAImmediate = 8'h77;
        #1;
        checks++; if (BusMuxOut !== 8'h0A) begin errors++; $display("FAIL move_bus: got %h expected 0a", BusMuxOut); end
        edge_sample();
        checks++; if (RBdata !== 8'h0A) begin errors++; $display("FAIL move_rb: got %h expected 0a", RBdata); end
        checks++; if ({RAdata, RZdata} !== 16'h050A) begin errors++; $display("FAIL move_seq: got ra=%h rz=%h expected ra=05 rz=0a", RAdata, RZdata); end
        @(negedge clock);
        idle();
    endtask

    task automatic test_hold_accumulate();
        @(negedge clock);
        RegisterAImmediate = 8'hEE; AddImmediate = 8'h44;
        repeat (3) edge_sample();
        checks++; if ({RAdata, RBdata, RZdata} !== 24'h050A0A) begin errors++; $display("FAIL hold: got %h %h %h expected 05 0a 0a", RAdata, RBdata, RZdata); end
        @(negedge clock);
        RZout = 1'b1; RZin = 1'b1; AddImmediate = 8'h03;
        edge_sample();
        checks++; if (RZdata !== 8'h0D) begin errors++; $display("FAIL acc1: got %h expected 0d", RZdata); end
        edge_sample();
        checks++; if (RZdata !== 8'h10) begin errors++; $display("FAIL acc2: got %h expected 10", RZdata); end
        @(negedge clock);
        idle();
    endtask

    task automatic test_wrap_priority();
        @(negedge clock);
        RegisterAImmediate = 8'hFF; RAin = 1'b1;
        @(negedge clock);
        idle();
        RegisterAImmediate = 8'h11; RBin = 1'b1;
        @(negedge clock);
        idle();
        RAout = 1'b1; RBout = 1'b1; AddImmediate = 8'h01; RZin = 1'b1;
        #1;
        checks++; if (BusMuxOut !== 8'hFF) begin errors++; $display("FAIL prio_ab: got %h expected ff", BusMuxOut); end
        edge_sample();
        checks++; if (RZdata !== 8'h00) begin errors++; $display("FAIL wrap_rz: got %h expected 00", RZdata); end
`ifdef DATAPATH_CARRY_EN
        checks++; if (ZCarry !== 1'b1) begin errors++; $display("FAIL carry_set: got %b expected 1", ZCarry); end
`endif
        @(negedge clock);
        idle();
        RZout = 1'b1; RAout = 1'b1; RBout = 1'b1;
        #1;
        checks++; if (BusMuxOut !== 8'h00) begin errors++; $display("FAIL prio_z: got %h expected 00", BusMuxOut); end
        RZout = 1'b0;
        #1;
        checks++; if (BusMuxOut !== 8'hFF) begin errors++; $display("FAIL prio_a: got %h expected ff", BusMuxOut); end
        RAout = 1'b0;
        #1;
        checks++; if (BusMuxOut !== 8'h11) begin errors++; $display("FAIL prio_b: got %h expected 11", BusMuxOut); end
        idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        RAout = 1'b1; RAin = 1'b1; RBin = 1'b1; RZin = 1'b1; AddImmediate = 8'h02;
        edge_sample();
        checks++; if ({RAdata, RBdata, RZdata} !== 24'hFFFF01) begin errors++; $display("FAIL multi_load: got %h %h %h expected ff ff 01", RAdata, RBdata, RZdata); end
`ifdef DATAPATH_CARRY_EN
        checks++; if (ZCarry !== 1'b1) begin errors++; $display("FAIL carry_multi: got %b expected 1", ZCarry); end
`endif
        @(negedge clock);
        idle();
        RZout = 1'b1; RZin = 1'b1; AddImmediate = 8'h01;
        edge_sample();
        checks++; if (RZdata !== 8'h02) begin errors++; $display("FAIL zself: got %h expected 02", RZdata); end
`ifdef DATAPATH_CARRY_EN
        checks++; if (ZCarry !== 1'b0) begin errors++; $display("FAIL carry_clr: got %b expected 0", ZCarry); end
`endif
        @(negedge clock);
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        RegisterAImmediate = 8'h77; RAin = 1'b1; RZin = 1'b1;
        #2;
        clear = 1'b0;
        #1;
        checks++; if ({RAdata, RBdata, RZdata} !== 24'h0) begin errors++; $display("FAIL reset_async: got %h %h %h expected 00 00 00", RAdata, RBdata, RZdata); end
        edge_sample();
        checks++; if ({RAdata, RZdata} !== 16'h0) begin errors++; $display("FAIL reset_hold: got %h %h expected 00 00", RAdata, RZdata); end
        @(negedge clock);
        clear = 1'b1;
        RegisterAImmediate = 8'h42;
        edge_sample();
        checks++; if (RAdata !== 8'h42) begin errors++; $display("FAIL reset_release: got %h expected 42", RAdata); end
        @(negedge clock);
        idle();
    endtask

    initial begin
        test_reset();
        test_immediate_load();
        test_add();
        test_move();
        test_hold_accumulate();
        test_wrap_priority();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
